// File: rtl/ooo_pkg.sv
// Shared types and widths for the out-of-order execution slice.
package ooo_pkg;

    localparam int unsigned ROBID_W      = 4;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned ALU_RS_DEPTH = 4;

    // Bit of the flags field that marks source 1 as an immediate.
    localparam int unsigned FLAG_IMM = 2;

    typedef struct packed {
        logic [ROBID_W-1:0] tag;
        logic               rdy;
        logic [DATA_W-1:0]  val;
    } src_t;

    typedef struct packed {
        logic               valid;
        logic [7:0]         operand;
        logic [7:0]         wbs;
        logic [7:0]         flags;
        logic [ROBID_W-1:0] robid;
        src_t [1:0]         src;
    } rs_entry_t;

    // Build a source operand at dispatch, catching a same-cycle CDB broadcast.
    function automatic src_t make_src(
        input logic [ROBID_W-1:0] tag,
        input logic               rdy,
        input logic [DATA_W-1:0]  val,
        input logic               cdb_transmit,
        input logic [ROBID_W-1:0] cdb_id,
        input logic [DATA_W-1:0]  cdb_val
    );
        src_t s;
        s.tag = tag;
        s.rdy = rdy;
        s.val = val;
        if (!rdy && cdb_transmit && (cdb_id == tag)) begin
            s.rdy = 1'b1;
            s.val = cdb_val;
        end
        return s;
    endfunction

endpackage

// File: rtl/rs_oldest_pick.sv
// Oldest-first selector: older[j][i] set means slot j was dispatched before slot i.
module rs_oldest_pick
    import ooo_pkg::*;
#(
    parameter int unsigned DEPTH = ALU_RS_DEPTH
) (
    input  logic [DEPTH-1:0]            issuable,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic                        found
);

    // A slot wins when no other issuable slot is older than it.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = issuable[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && issuable[j] && older[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

    assign found = |issuable;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both sources are ready,
// then issues the oldest ready op to the ALU functional unit.
module alu_rs
    import ooo_pkg::*;
#(
    parameter int unsigned DEPTH = ALU_RS_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_transmit,
    input  logic [7:0]  disp_operand,
    input  logic [7:0]  disp_wbs,
    input  logic [7:0]  disp_flags,
    input  logic [3:0]  disp_robid,
    input  logic [7:0]  disp_tags,
    input  logic [1:0]  disp_rdy,
    input  logic [15:0] disp_vals,
    output logic        disp_ready,
    input  logic        cdb_transmit,
    input  logic [3:0]  cdb_id,
    input  logic [7:0]  cdb_val,
    input  logic        flush,
    input  logic        fu_busy,
    output logic        input_transmit,
    output logic [7:0]  operand,
    output logic [7:0]  wbs,
    output logic [7:0]  flags,
    output logic [15:0] depvals,
    output logic [3:0]  robid
);

    rs_entry_t                 entries     [DEPTH];
    rs_entry_t                 entries_nxt [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] older, older_nxt;
    logic [DEPTH-1:0]          valid_vec, issuable, grant, free_oh;
    logic                      found, found_free, issue, do_disp;
    rs_entry_t                 new_ent;

    // Start-of-cycle occupancy and readiness; CDB wakeups only count next cycle.
    always_comb begin
        valid_vec = '0;
        issuable  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries[i].valid;
            issuable[i]  = entries[i].valid & entries[i].src[0].rdy & entries[i].src[1].rdy;
        end
    end

    assign disp_ready = ~&valid_vec;
    assign issue      = found & ~fu_busy;
    assign do_disp    = disp_transmit & disp_ready;

    rs_oldest_pick #(
        .DEPTH (DEPTH)
    ) u_pick (
        .issuable (issuable),
        .older    (older),
        .grant    (grant),
        .found    (found)
    );

    // Lowest free slot receives the dispatch; age is tracked separately.
    always_comb begin
        free_oh    = '0;
        found_free = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_vec[i] && !found_free) begin
                free_oh[i] = 1'b1;
                found_free = 1'b1;
            end
        end
    end

    // Incoming entry; an immediate form makes source 1 ready unconditionally.
    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.operand = disp_operand;
        new_ent.wbs     = disp_wbs;
        new_ent.flags   = disp_flags;
        new_ent.robid   = disp_robid;
        new_ent.src[0]  = make_src(disp_tags[3:0], disp_rdy[0], disp_vals[7:0],
                                   cdb_transmit, cdb_id, cdb_val);
        new_ent.src[1]  = make_src(disp_tags[7:4], disp_rdy[1] | disp_flags[FLAG_IMM],
                                   disp_vals[15:8], cdb_transmit, cdb_id, cdb_val);
    end

    // Next entry state: CDB capture, free on issue, write of the new entry.
    always_comb begin
        older_nxt = older;
        for (int i = 0; i < DEPTH; i++) begin
            entries_nxt[i] = entries[i];
            for (int s = 0; s < 2; s++) begin
                if (cdb_transmit && entries[i].valid && !entries[i].src[s].rdy &&
                    (entries[i].src[s].tag == cdb_id)) begin
                    entries_nxt[i].src[s].rdy = 1'b1;
                    entries_nxt[i].src[s].val = cdb_val;
                end
            end
            if (issue && grant[i]) begin
                entries_nxt[i].valid = 1'b0;
            end
            if (do_disp && free_oh[i]) begin
                entries_nxt[i] = new_ent;
            end
        end
        // New entry is younger than every occupant; stale bits of empty slots are masked later.
        if (do_disp) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (free_oh[k]) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        older_nxt[j][k] = valid_vec[j];
                        older_nxt[k][j] = 1'b0;
                    end
                end
            end
        end
    end

    // State and registered issue outputs; rst beats flush beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            older          <= '0;
            input_transmit <= 1'b0;
            operand        <= '0;
            wbs            <= '0;
            flags          <= '0;
            depvals        <= '0;
            robid          <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
            input_transmit <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= entries_nxt[i];
            end
            older          <= older_nxt;
            input_transmit <= issue;
            for (int i = 0; i < DEPTH; i++) begin
                if (issue && grant[i]) begin
                    operand <= entries[i].operand;
                    wbs     <= entries[i].wbs;
                    flags   <= entries[i].flags;
                    robid   <= entries[i].robid;
                    depvals <= {entries[i].src[1].val, entries[i].src[0].val};
                end
            end
        end
    end

endmodule
